// File: rtl/priority_encoder_8to3_if.sv
// priority_encoder_8to3_if: request/grant bundle; master drives enable/in/ready, slave returns out/valid/pending/merged/busy
interface priority_encoder_8to3_if;
  logic enable;
  logic [7:0] in;
  logic ready;
  logic [2:0] out;
  logic valid;
  logic [7:0] pending;
  logic merged;
  logic busy;
  modport master(output enable, in, ready, input out, valid, pending, merged, busy);
  modport slave(input enable, in, ready, output out, valid, pending, merged, busy);
endinterface

// File: rtl/priority_encoder_8to3.sv
// priority_encoder_8to3: latches 8 request lines and grants one 3-bit index per valid/ready handshake (clk, rst_n, bus slave)
module priority_encoder_8to3 #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input logic clk,
  input logic rst_n,
  priority_encoder_8to3_if.slave bus
);
  logic [7:0] pend, set, clr, rot;
  logic [2:0] ptr, off, sel, out_r;
  logic valid_r, merged_r, load;
  assign set = bus.in & {8{bus.enable}};
  assign load = (!valid_r | bus.ready) & (|pend);
  assign rot = 8'({pend, pend} >> ptr);
  always_comb begin
    off = '0;
    for (int i = 7; i >= 0; i--) if (rot[i]) off = 3'(i);
  end
  assign sel = ptr + off;
  assign clr = load ? 8'(1) << sel : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      ptr <= '0;
      out_r <= '0;
      valid_r <= 1'b0;
      merged_r <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | set;
      merged_r <= |(set & pend & ~clr);
      if (load) begin
        out_r <= sel;
        valid_r <= 1'b1;
        if (ROUND_ROBIN) ptr <= sel + 3'd1;
      end else if (bus.ready) begin
        valid_r <= 1'b0;
      end
    end
  end
  assign bus.out = out_r;
  assign bus.valid = valid_r;
  assign bus.pending = pend;
  assign bus.merged = merged_r;
  assign bus.busy = valid_r | (|pend);
endmodule

// File: tb/tb_priority_encoder_8to3.sv
// tb_priority_encoder_8to3: checks fixed and round-robin encoders against vectors, directed sequences and a reference model
module tb_priority_encoder_8to3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [7:0] req = '0;
  logic rdy = 1'b0;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;

  priority_encoder_8to3_if if0();
  priority_encoder_8to3_if if1();
  assign if0.enable = en;
  assign if0.in = req;
  assign if0.ready = rdy;
  assign if1.enable = en;
  assign if1.in = req;
  assign if1.ready = rdy;

  priority_encoder_8to3 #(.ROUND_ROBIN(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  priority_encoder_8to3 #(.ROUND_ROBIN(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  typedef struct {
    logic [7:0] pend;
    logic [2:0] out;
    logic valid;
    logic merged;
    int ptr;
  } st_t;

  st_t m0, m1;

  function automatic st_t step(st_t s, bit rr, logic e, logic [7:0] r, logic y);
    st_t n = s;
    logic [7:0] set = e ? r : 8'h00;
    logic [7:0] clr = 8'h00;
    int k = -1;
    if ((!s.valid || y) && s.pend != 8'h00) begin
      for (int j = 0; j < 8; j++)
        if (k < 0 && s.pend[(s.ptr + j) % 8]) k = (s.ptr + j) % 8;
      clr[k] = 1'b1;
      n.out = 3'(k);
      n.valid = 1'b1;
      if (rr) n.ptr = (k + 1) % 8;
    end else if (s.valid && y) begin
      n.valid = 1'b0;
    end
    n.pend = (s.pend & ~clr) | set;
    n.merged = |(set & s.pend & ~clr);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '{8'h00, 3'd0, 1'b0, 1'b0, 0};
      m1 <= '{8'h00, 3'd0, 1'b0, 1'b0, 0};
    end else begin
      m0 <= step(m0, 1'b0, en, req, rdy);
      m1 <= step(m1, 1'b1, en, req, rdy);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_fixed"}, {if0.out, if0.valid, if0.pending, if0.merged, if0.busy},
        {m0.out, m0.valid, m0.pend, m0.merged, m0.valid | (|m0.pend)});
    chk({tag, "_rr"}, {if1.out, if1.valid, if1.pending, if1.merged, if1.busy},
        {m1.out, m1.valid, m1.pend, m1.merged, m1.valid | (|m1.pend)});
  endtask

  task automatic drive(logic e, logic [7:0] r, logic y);
    en = e;
    req = r;
    rdy = y;
    @(posedge clk);
    #1;
    chk_model("model");
  endtask

  typedef struct {
    logic e;
    logic [7:0] r;
    logic y;
    logic [2:0] out0;
    logic valid;
    logic [7:0] pend;
    logic [2:0] out1;
  } vec_t;

  vec_t vt[8];
  int mcnt;

  initial begin
    vt[0] = '{1'b1, 8'h04, 1'b1, 3'd0, 1'b0, 8'h04, 3'd0};
    vt[1] = '{1'b1, 8'h00, 1'b1, 3'd2, 1'b1, 8'h00, 3'd2};
    vt[2] = '{1'b1, 8'h00, 1'b1, 3'd2, 1'b0, 8'h00, 3'd2};
    vt[3] = '{1'b1, 8'hA1, 1'b1, 3'd2, 1'b0, 8'hA1, 3'd2};
    vt[4] = '{1'b1, 8'h00, 1'b1, 3'd0, 1'b1, 8'hA0, 3'd5};
    vt[5] = '{1'b1, 8'h00, 1'b1, 3'd5, 1'b1, 8'h80, 3'd7};
    vt[6] = '{1'b1, 8'h00, 1'b1, 3'd7, 1'b1, 8'h00, 3'd0};
    vt[7] = '{1'b1, 8'h00, 1'b1, 3'd7, 1'b0, 8'h00, 3'd0};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {if0.out, if0.valid, if0.pending, if0.merged, if0.busy}, 14'h0);
    chk_model("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].e, vt[i].r, vt[i].y);
      chk($sformatf("vec%0d_fixed", i), {if0.out, if0.valid, if0.pending}, {vt[i].out0, vt[i].valid, vt[i].pend});
      chk($sformatf("vec%0d_rr_out", i), if1.out, vt[i].out1);
    end
    chk("idle_busy", {if0.busy, if1.busy}, 2'b00);

    drive(1'b1, 8'h40, 1'b1);
    drive(1'b1, 8'h00, 1'b1);
    chk("rr_grant6", {if1.out, if1.valid}, {3'd6, 1'b1});
    drive(1'b1, 8'h81, 1'b1);
    drive(1'b1, 8'h00, 1'b1);
    chk("rr_wrap7", {if1.out, if1.valid}, {3'd7, 1'b1});
    chk("fixed_0_first", {if0.out, if0.valid}, {3'd0, 1'b1});
    drive(1'b1, 8'h00, 1'b1);
    chk("rr_wrap0", {if1.out, if1.valid}, {3'd0, 1'b1});
    drive(1'b1, 8'h81, 1'b1);
    drive(1'b1, 8'h00, 1'b1);
    chk("rr_ptr_is_1", if1.out, 3'd7);
    drive(1'b1, 8'h00, 1'b1);
    drive(1'b1, 8'h00, 1'b1);
    chk("drained", {if0.valid, if1.valid}, 2'b00);

    mcnt = 0;
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    chk("bp_slot", {if0.out, if0.valid}, {3'd1, 1'b1});
    drive(1'b1, 8'h08, 1'b0); mcnt += int'(if0.merged);
    drive(1'b1, 8'h00, 1'b0); mcnt += int'(if0.merged);
    drive(1'b1, 8'h08, 1'b0); mcnt += int'(if0.merged);
    drive(1'b1, 8'h00, 1'b0); mcnt += int'(if0.merged);
    chk("merge_once", mcnt, 1);
    chk("bp_hold", {if0.out, if0.valid, if0.pending}, {3'd1, 1'b1, 8'h08});
    drive(1'b1, 8'h00, 1'b1);
    chk("bp_grant3", {if0.out, if0.valid, if0.pending}, {3'd3, 1'b1, 8'h00});
    drive(1'b1, 8'h00, 1'b1);
    chk("bp_single_grant", {if0.valid, if0.busy}, 2'b00);

    drive(1'b0, 8'hFF, 1'b1);
    drive(1'b0, 8'hFF, 1'b1);
    chk("enable_gate", {if0.pending, if1.pending}, 16'h0);
    drive(1'b1, 8'h10, 1'b1);
    drive(1'b1, 8'h10, 1'b1);
    chk("set_wins", {if0.out, if0.valid, if0.pending, if0.merged}, {3'd4, 1'b1, 8'h10, 1'b0});
    drive(1'b1, 8'h00, 1'b1);
    chk("regrant", {if0.out, if0.valid, if0.pending}, {3'd4, 1'b1, 8'h00});
    drive(1'b1, 8'h00, 1'b1);

    drive(1'b1, 8'hF1, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    chk("pre_reset", {if0.valid, if0.pending}, {1'b1, 8'hF0});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {if0.out, if0.valid, if0.pending, if0.merged, if0.busy}, 14'h0);
    chk("async_reset_rr", {if1.out, if1.valid, if1.pending, if1.merged, if1.busy}, 14'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h00, 1'b1);
    drive(1'b1, 8'h00, 1'b1);
    chk("post_reset_idle", {if0.valid, if1.valid}, 2'b00);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      drive(1'($urandom_range(0, 5) != 0), r, 1'($urandom_range(0, 2) != 0));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
